// File: rtl/comparador_serial.sv
// comparador_serial
//   Bit-serial equality/inequality comparator. On an accepted start it latches
//   two WIDTH-bit operands and a mode key, then examines one bit per clock,
//   LSB first, stopping at the first mismatching bit. The selected relation is
//   reported with a one-cycle done pulse.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   start     : request, sampled only in IDLE or DONE
//   a, b      : operands, latched when start is accepted
//   chave     : mode key, 0 = equality (a==b), 1 = inequality (a!=b)
//   busy      : high while comparing
//   done      : one-cycle pulse when the result is ready
//   resultado : relation result, held until the next result or reset
//   ciclos    : bits examined by the last operation, held with resultado
module comparador_serial #(
    parameter int WIDTH = 6,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             chave,
    output logic             busy,
    output logic             done,
    output logic             resultado,
    output logic [CW-1:0]    ciclos
);

    // Index only needs to reach WIDTH-1.
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic             k_q,         k_d;
    logic [IW-1:0]    idx_q,       idx_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             resultado_q, resultado_d;
    logic [CW-1:0]    ciclos_q,    ciclos_d;

    logic             bit_diff;
    logic             last_bit;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        k_d         = k_q;
        idx_d       = idx_q;
        resultado_d = resultado_q;
        ciclos_d    = ciclos_q;

        bit_diff = a_q[idx_q] ^ b_q[idx_q];
        last_bit = (idx_q == IW'(WIDTH - 1));

        case (state_q)
            // DONE accepts start exactly like IDLE, giving back-to-back operation.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    k_d     = chave;
                    idx_d   = '0;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (bit_diff) begin
                    // Operands differ: inequality holds, equality fails.
                    state_d     = S_DONE;
                    ciclos_d    = CW'(idx_q) + CW'(1);
                    resultado_d = k_q;
                end else if (last_bit) begin
                    // All bits matched: equality holds, inequality fails.
                    state_d     = S_DONE;
                    ciclos_d    = CW'(WIDTH);
                    resultado_d = ~k_q;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered copies of the next-state decode.
        busy_d = (state_d == S_COMPARE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= 1'b0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            resultado_q <= 1'b0;
            ciclos_q    <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            resultado_q <= resultado_d;
            ciclos_q    <= ciclos_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign resultado = resultado_q;
    assign ciclos    = ciclos_q;

endmodule

// File: tb/tb_comparador_serial.sv
// tb_comparador_serial
//   Directed and randomized stimulus for comparador_serial. Expected results
//   come from a plain-arithmetic reference: bits examined is the position of
//   the lowest differing bit plus one (WIDTH when equal), result is the
//   requested relation evaluated on whole operands.
module tb_comparador_serial;

    localparam int W  = 6;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          chave;
    logic          busy;
    logic          done;
    logic          resultado;
    logic [CW-1:0] ciclos;

    int total = 0;
    int bad   = 0;

    // Reference view of the held outputs.
    bit ref_res = 1'b0;
    int ref_cyc = 0;

    comparador_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .chave     (chave),
        .busy      (busy),
        .done      (done),
        .resultado (resultado),
        .ciclos    (ciclos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Relation and bit count computed on whole operands.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic kv,
                         output int cyc, output bit res);
        int unsigned diff;
        diff = int'(av) ^ int'(bv);
        if (diff == 0) cyc = W;
        else begin
            cyc = 1;
            while (((diff >> (cyc - 1)) & 1) == 0) cyc++;
        end
        res = kv ? (av != bv) : (av == bv);
    endtask

    // Called right after the acceptance edge; returns at the negedge of DONE.
    task automatic check_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic kv);
        int cyc;
        bit res;
        model(av, bv, kv, cyc, res);
        for (int n = 0; n <= cyc; n++) begin
            @(negedge clk);
            if (n < cyc) begin
                chk("busy_run", busy, 1);
                chk("done_run", done, 0);
                chk("res_hold", resultado, ref_res);
                chk("cyc_hold", ciclos, ref_cyc);
            end else begin
                chk("busy_done", busy, 0);
                chk("done_pulse", done, 1);
                chk("resultado", resultado, res);
                chk("ciclos", ciclos, cyc);
                ref_res = res;
                ref_cyc = cyc;
            end
        end
    endtask

    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic kv,
                          input bit idle_gap);
        if (idle_gap) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_res", resultado, ref_res);
            chk("idle_cyc", ciclos, ref_cyc);
        end
        start = 1'b1;
        a     = av;
        b     = bv;
        chave = kv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~av;
        b     = W'($urandom);
        chave = ~kv;
        check_op(av, bv, kv);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rk;

        // Reset held two cycles with start asserted.
        rst_n = 1'b0;
        start = 1'b1;
        a     = 6'b101101;
        b     = 6'b010010;
        chave = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_res", resultado, 0);
            chk("rst_cyc", ciclos, 0);
        end
        rst_n = 1'b1;
        start = 1'b0;

        // Directed operations.
        launch(6'b000000, 6'b000000, 1'b0, 1'b1);
        launch(6'b000001, 6'b000010, 1'b1, 1'b1);
        launch(6'b111111, 6'b011111, 1'b0, 1'b1);
        launch(6'b100000, 6'b000000, 1'b1, 1'b1);
        launch(6'b010101, 6'b010101, 1'b1, 1'b1);

        // Operands change while start stays high; the DONE cycle takes the new request.
        @(negedge clk);
        start = 1'b1;
        a     = 6'b111111;
        b     = 6'b111111;
        chave = 1'b0;
        @(posedge clk);
        #1;
        a = 6'b000000;
        check_op(6'b111111, 6'b111111, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_op(6'b000000, 6'b111111, 1'b0);

        // Reset on the third COMPARE cycle abandons the operation.
        @(negedge clk);
        start = 1'b1;
        a     = 6'b101010;
        b     = 6'b101010;
        chave = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy1", busy, 1);
        @(negedge clk);
        chk("pre_rst_busy2", busy, 1);
        @(negedge clk);
        chk("pre_rst_busy3", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_res", resultado, 0);
        chk("midrst_cyc", ciclos, 0);
        rst_n   = 1'b1;
        ref_res = 1'b0;
        ref_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", done, 0);
            chk("no_busy_after_rst", busy, 0);
        end
        launch(6'b101010, 6'b101010, 1'b0, 1'b1);

        // Randomized operations, mixing idle gaps and back-to-back starts.
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            rb = ra;
            if ($urandom_range(0, 3) != 0) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 3) == 0) rb = W'($urandom);
            rk = 1'($urandom);
            launch(ra, rb, rk, 1'($urandom));
        end

        @(negedge clk);
        chk("final_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
